// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit for the EX stage; owns the HI/LO registers.
// Operands are latched at start, and the result commits to HI/LO on the final busy edge.
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic        mt_hi,
    input  logic        mt_lo,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MADD  = 3'd4;

    localparam logic [3:0] MULT_N = MULT_CYCLES[3:0];
    localparam logic [3:0] DIV_N  = DIV_CYCLES[3:0];

    state_t      state;
    state_t      state_next;
    logic [3:0]  count;
    logic [2:0]  op_q;
    logic [31:0] a_q;
    logic [31:0] b_q;

    logic        op_legal;
    logic        op_is_div;
    logic        accept;
    logic        finish;

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic        div_zero;
    logic        div_ovf;
    logic signed [31:0] sa;
    logic signed [31:0] sb_safe;
    logic signed [31:0] quo_s;
    logic signed [31:0] rem_s;
    logic [31:0] ub_safe;
    logic [31:0] quo_u;
    logic [31:0] rem_u;
    logic        commit;
    logic [63:0] result;

    assign op_legal  = (md_op <= OP_MADD);
    assign op_is_div = (md_op == OP_DIV) || (md_op == OP_DIVU);
    assign accept    = (state == IDLE) && start && op_legal;
    assign finish    = (state == RUN) && (count == 4'd1);
    assign busy      = (state == RUN);

    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every output of a combinational block gets a default first, so no latch is inferred.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept) state_next = RUN;
            RUN:  if (count == 4'd1) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Products are formed in 64 bits; only the low 64 bits matter, so sign-extended
    // operands give the signed product directly.
    assign prod_s = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
    assign prod_u = {32'd0, a_q} * {32'd0, b_q};

    // The divisor is forced to 1 in the zero and overflow cases, which never commit the raw
    // quotient, so the divider never sees an undefined operation.
    assign div_zero = (b_q == 32'd0);
    assign div_ovf  = (a_q == 32'h8000_0000) && (b_q == 32'hFFFF_FFFF);
    assign sa       = $signed(a_q);
    assign sb_safe  = (div_zero || div_ovf) ? 32'sd1 : $signed(b_q);
    assign quo_s    = sa / sb_safe;
    assign rem_s    = sa % sb_safe;
    assign ub_safe  = div_zero ? 32'd1 : b_q;
    assign quo_u    = a_q / ub_safe;
    assign rem_u    = a_q % ub_safe;

    always_comb begin
        result = {hi, lo};
        commit = 1'b0;
        case (op_q)
            OP_MULT: begin
                result = prod_s;
                commit = 1'b1;
            end
            OP_MULTU: begin
                result = prod_u;
                commit = 1'b1;
            end
            OP_MADD: begin
                result = {hi, lo} + prod_s;
                commit = 1'b1;
            end
            OP_DIV: begin
                if (!div_zero) begin
                    result = div_ovf ? {32'd0, 32'h8000_0000} : {rem_s, quo_s};
                    commit = 1'b1;
                end
            end
            OP_DIVU: begin
                if (!div_zero) begin
                    result = {rem_u, quo_u};
                    commit = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= 4'd0;
            op_q  <= 3'd0;
            a_q   <= 32'd0;
            b_q   <= 32'd0;
            hi    <= 32'd0;
            lo    <= 32'd0;
        end else begin
            if (accept) begin
                a_q   <= a;
                b_q   <= b;
                op_q  <= md_op;
                count <= op_is_div ? DIV_N : MULT_N;
            end else if (state == RUN) begin
                count <= count - 4'd1;
            end

            // mt writes are honoured only when idle and not colliding with an accepted start.
            if (finish && commit) begin
                {hi, lo} <= result;
            end else if ((state == IDLE) && !accept) begin
                if (mt_hi) hi <= a;
                if (mt_lo) lo <= a;
            end
        end
    end

endmodule
